// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state type and address-split width helpers for the instruction cache.
package icache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_e;
  function automatic int offset_w(int block_words, int data_width);
    return $clog2(block_words * data_width / 8);
  endfunction
  function automatic int index_w(int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(int addr_width, int sets, int block_words, int data_width);
    return addr_width - index_w(sets) - offset_w(block_words, data_width);
  endfunction
endpackage

// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch-side and L2-side signals of the instruction cache.
interface icache_assoc_if
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 8
);
  localparam int OFFSET = offset_w(BLOCK_WORDS, DATA_WIDTH);
  localparam int LINE   = BLOCK_WORDS * DATA_WIDTH;
  logic                       FLUSH;
  logic [ADDR_WIDTH-1:0]      ADDR;
  logic                       ADDR_VALID;
  logic [DATA_WIDTH-1:0]      DATA;
  logic                       CACHE_READY;
  logic                       ADDR_TO_L2_VALID;
  logic                       ADDR_TO_L2_READY;
  logic [ADDR_WIDTH-OFFSET-1:0] ADDR_TO_L2;
  logic [LINE-1:0]            DATA_FROM_L2;
  logic                       DATA_FROM_L2_VALID;
  modport slave (
    input  FLUSH, ADDR, ADDR_VALID, ADDR_TO_L2_READY, DATA_FROM_L2, DATA_FROM_L2_VALID,
    output DATA, CACHE_READY, ADDR_TO_L2_VALID, ADDR_TO_L2
  );
  modport master (
    output FLUSH, ADDR, ADDR_VALID, ADDR_TO_L2_READY, DATA_FROM_L2, DATA_FROM_L2_VALID,
    input  DATA, CACHE_READY, ADDR_TO_L2_VALID, ADDR_TO_L2
  );
endinterface

// File: rtl/icache_way.sv
// icache_way: one way's data/tag/valid arrays; async read, sync write, single-cycle valid clear.
module icache_way #(
  parameter int SETS   = 128,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [$clog2(SETS)-1:0] widx_i,
  input  logic [TAG_W-1:0]        wtag_i,
  input  logic [LINE_W-1:0]       wdata_i,
  input  logic [$clog2(SETS)-1:0] ridx_i,
  output logic                    rvalid_o,
  output logic [TAG_W-1:0]        rtag_o,
  output logic [LINE_W-1:0]       rdata_o
);
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  always_ff @(posedge CLK) begin
    if (RST || clr_i) valid_q <= '0;
    else if (we_i) valid_q[widx_i] <= 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end
  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with combinational hit path and a
// request/wait/fill miss FSM toward L2; victims are invalid-way-first, then per-set round-robin.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int SETS        = 128,
  parameter int WAYS        = 2
) (
  input logic           CLK,
  input logic           RST,
  icache_assoc_if.slave bus
);
  localparam int OFFSET = offset_w(BLOCK_WORDS, DATA_WIDTH);
  localparam int WOFF   = $clog2(DATA_WIDTH / 8);
  localparam int INDEX  = index_w(SETS);
  localparam int TAG    = tag_w(ADDR_WIDTH, SETS, BLOCK_WORDS, DATA_WIDTH);
  localparam int LINE   = BLOCK_WORDS * DATA_WIDTH;
  localparam int RR_W   = WAYS > 1 ? $clog2(WAYS) : 1;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] miss_q, miss_d;
  logic [LINE-1:0]       fill_q, fill_d;
  logic                  discard_q, discard_d;
  logic [RR_W-1:0]       rr_q [SETS];
  logic [INDEX-1:0]      mset, rset;
  logic [WAYS-1:0]       vv, hitv;
  logic [TAG-1:0]        rtag [WAYS];
  logic [LINE-1:0]       rline [WAYS];
  logic [LINE-1:0]       sel;
  logic [RR_W-1:0]       victim;
  logic                  all_v, we, hit;
  assign mset = miss_q[INDEX+OFFSET-1:OFFSET];
  // Outside IDLE the single read port looks at the miss set so the victim sees its valid bits.
  assign rset = state_q == IDLE ? bus.ADDR[INDEX+OFFSET-1:OFFSET] : mset;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(.SETS(SETS), .TAG_W(TAG), .LINE_W(LINE)) u_way (
      .CLK(CLK), .RST(RST), .clr_i(bus.FLUSH), .we_i(we && victim == RR_W'(w)),
      .widx_i(mset), .wtag_i(miss_q[ADDR_WIDTH-1 -: TAG]), .wdata_i(fill_q),
      .ridx_i(rset), .rvalid_o(vv[w]), .rtag_o(rtag[w]), .rdata_o(rline[w])
    );
    assign hitv[w] = vv[w] && rtag[w] == bus.ADDR[ADDR_WIDTH-1 -: TAG];
  end
  assign hit = state_q == IDLE && bus.ADDR_VALID && $onehot(hitv);
  always_comb begin
    sel = '0;
    for (int w = 0; w < WAYS; w++) sel = sel | (hitv[w] ? rline[w] : '0);
  end
  assign bus.CACHE_READY      = hit;
  assign bus.DATA             = hit ? sel[bus.ADDR[OFFSET-1:WOFF]*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.ADDR_TO_L2_VALID = state_q == REQ;
  assign bus.ADDR_TO_L2       = state_q == REQ ? miss_q[ADDR_WIDTH-1:OFFSET] : '0;
  always_comb begin
    victim = rr_q[mset];
    all_v  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vv[w]) begin
        victim = RR_W'(w);
        all_v  = 1'b0;
      end
    end
  end
  always_comb begin
    state_d   = state_q;
    miss_d    = miss_q;
    fill_d    = fill_q;
    discard_d = discard_q;
    we        = 1'b0;
    case (state_q)
      IDLE: if (!bus.FLUSH && bus.ADDR_VALID && !hit) begin
        state_d = REQ;
        miss_d  = bus.ADDR;
      end
      REQ: begin
        discard_d = discard_q | bus.FLUSH;
        if (bus.ADDR_TO_L2_READY) state_d = WAIT;
      end
      WAIT: begin
        discard_d = discard_q | bus.FLUSH;
        if (bus.DATA_FROM_L2_VALID) begin
          state_d   = discard_d ? IDLE : FILL;
          fill_d    = bus.DATA_FROM_L2;
          discard_d = 1'b0;
        end
      end
      FILL: begin
        we      = !bus.FLUSH;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      miss_q    <= '0;
      fill_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      miss_q    <= miss_d;
      fill_q    <= fill_d;
      discard_q <= discard_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST || bus.FLUSH) for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    else if (we && all_v) rr_q[mset] <= RR_W'((int'(rr_q[mset]) + 1) % WAYS);
  end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: randomized and directed checks of icache_assoc against a behavioural cache model.
module tb_icache_assoc;
  localparam int DW = 32, AW = 32, BW = 8, SETS = 128, WAYS = 2;
  logic CLK = 0;
  logic RST = 1;
  always #5 CLK = ~CLK;
  icache_assoc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) bus ();
  icache_assoc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW), .SETS(SETS), .WAYS(WAYS)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  int n_checks = 0, n_fail = 0;
  bit          m_v [SETS][WAYS];
  logic [19:0] m_t [SETS][WAYS];
  logic [255:0] m_d [SETS][WAYS];
  int          m_rr [SETS];

  function automatic void m_flush();
    foreach (m_v[s, w]) m_v[s][w] = 0;
    foreach (m_rr[s]) m_rr[s] = 0;
  endfunction

  function automatic void m_look(input logic [31:0] a, output bit hit, output logic [31:0] word);
    int s = int'((a >> 5) % SETS);
    int n = 0;
    word = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_t[s][w] == a[31:12]) begin
        n++;
        word = m_d[s][w][int'((a >> 2) % 8) * 32 +: 32];
      end
    hit = n == 1;
    if (!hit) word = 0;
  endfunction

  function automatic void m_fill(input logic [31:0] a, input logic [255:0] line);
    int s = int'((a >> 5) % SETS);
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (!m_v[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_v[s][v] = 1;
    m_t[s][v] = a[31:12];
    m_d[s][v] = line;
  endfunction

  function automatic logic [255:0] mk_line(input logic [26:0] la, input logic [31:0] salt);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = ({5'd0, la} * 2 + i) ^ salt;
    return l;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // fl: 0 none, 1 flush during WAIT, 2 flush during FILL; alt is the ADDR presented from WAIT onward.
  task automatic fetch(input logic [31:0] a, input int rdly, input int vdly, input int fl,
                       input logic [31:0] alt, input logic [31:0] salt);
    bit hit;
    logic [31:0] w;
    logic [255:0] line;
    bus.ADDR = a;
    bus.ADDR_VALID = 1;
    #1;
    m_look(a, hit, w);
    n_checks++;
    if (bus.CACHE_READY !== hit || bus.DATA !== w) begin
      n_fail++;
      $display("FAIL lookup %h: ready=%b data=%h, expected ready=%b data=%h", a, bus.CACHE_READY, bus.DATA, hit, w);
    end
    if (!hit) begin
      tick();
      for (int i = 0; i <= rdly; i++) begin
        bus.ADDR_TO_L2_READY = (i == rdly);
        #1;
        n_checks++;
        if (bus.ADDR_TO_L2_VALID !== 1'b1 || bus.ADDR_TO_L2 !== a[31:5] || bus.CACHE_READY !== 1'b0) begin
          n_fail++;
          $display("FAIL request %h cycle %0d: valid=%b line=%h ready=%b, expected 1 %h 0", a, i,
                   bus.ADDR_TO_L2_VALID, bus.ADDR_TO_L2, bus.CACHE_READY, a[31:5]);
        end
        tick();
      end
      bus.ADDR_TO_L2_READY = 0;
      bus.ADDR = alt;
      #1;
      n_checks++;
      if (bus.ADDR_TO_L2_VALID !== 1'b0 || bus.CACHE_READY !== 1'b0 || bus.DATA !== 32'h0) begin
        n_fail++;
        $display("FAIL wait %h: l2valid=%b ready=%b data=%h, expected 0 0 0", a, bus.ADDR_TO_L2_VALID, bus.CACHE_READY, bus.DATA);
      end
      repeat (vdly) tick();
      if (fl == 1) begin
        bus.FLUSH = 1;
        tick();
        bus.FLUSH = 0;
        m_flush();
      end
      line = mk_line(a[31:5], salt);
      bus.DATA_FROM_L2 = line;
      bus.DATA_FROM_L2_VALID = 1;
      tick();
      bus.DATA_FROM_L2_VALID = 0;
      if (fl != 1) begin
        n_checks++;
        if (bus.CACHE_READY !== 1'b0 || bus.ADDR_TO_L2_VALID !== 1'b0) begin
          n_fail++;
          $display("FAIL fill %h: ready=%b l2valid=%b, expected 0 0", a, bus.CACHE_READY, bus.ADDR_TO_L2_VALID);
        end
        bus.FLUSH = (fl == 2);
        tick();
        bus.FLUSH = 0;
        if (fl == 2) m_flush();
        else m_fill(a, line);
      end
      m_look(alt, hit, w);
      n_checks++;
      if (bus.CACHE_READY !== hit || bus.DATA !== w) begin
        n_fail++;
        $display("FAIL after-miss %h: ready=%b data=%h, expected ready=%b data=%h", alt, bus.CACHE_READY, bus.DATA, hit, w);
      end
    end
    bus.ADDR_VALID = 0;
  endtask

  task automatic test_reset();
    bus.FLUSH = 0; bus.ADDR = 0; bus.ADDR_VALID = 0; bus.ADDR_TO_L2_READY = 0;
    bus.DATA_FROM_L2 = '0; bus.DATA_FROM_L2_VALID = 0;
    RST = 1;
    repeat (3) tick();
    RST = 0;
    m_flush();
    #1;
    n_checks++;
    if (bus.CACHE_READY !== 1'b0 || bus.DATA !== 32'h0 || bus.ADDR_TO_L2_VALID !== 1'b0 || bus.ADDR_TO_L2 !== 27'h0) begin
      n_fail++;
      $display("FAIL reset: ready=%b data=%h l2valid=%b l2addr=%h, expected all 0", bus.CACHE_READY, bus.DATA, bus.ADDR_TO_L2_VALID, bus.ADDR_TO_L2);
    end
  endtask

  task automatic test_cold_miss();
    fetch(32'h1000, 0, 0, 0, 32'h1000, 0);
    bus.ADDR = 32'h1000; bus.ADDR_VALID = 1; #1;
    n_checks++;
    if (bus.CACHE_READY !== 1'b1 || bus.DATA !== 32'h100) begin
      n_fail++; $display("FAIL cold word0: ready=%b data=%h, expected 1 00000100", bus.CACHE_READY, bus.DATA);
    end
    bus.ADDR = 32'h1004; #1;
    n_checks++;
    if (bus.CACHE_READY !== 1'b1 || bus.DATA !== 32'h101) begin
      n_fail++; $display("FAIL cold word1: ready=%b data=%h, expected 1 00000101", bus.CACHE_READY, bus.DATA);
    end
    bus.ADDR_VALID = 0;
  endtask

  task automatic probe(input logic [31:0] a, input bit exp);
    bus.ADDR = a; bus.ADDR_VALID = 1; #1;
    n_checks++;
    if (bus.CACHE_READY !== exp) begin
      n_fail++; $display("FAIL probe %h: ready=%b, expected %b", a, bus.CACHE_READY, exp);
    end
    bus.ADDR_VALID = 0;
  endtask

  task automatic test_replacement();
    fetch(32'h2000, 0, 0, 0, 32'h2000, 0);
    fetch(32'h1000, 0, 0, 0, 32'h1000, 0);
    fetch(32'h2000, 0, 0, 0, 32'h2000, 0);
    fetch(32'h3000, 0, 1, 0, 32'h3000, 0);
    probe(32'h2000, 1);
    probe(32'h1000, 0);
    fetch(32'h1000, 0, 0, 0, 32'h1000, 0);
    probe(32'h2000, 0);
    probe(32'h3000, 1);
  endtask

  task automatic test_backpressure();
    fetch(32'h4000, 5, 2, 0, 32'h4000, 32'h5a5a0000);
  endtask

  task automatic test_flush_idle();
    bus.ADDR = 32'h6000; bus.ADDR_VALID = 1; bus.FLUSH = 1;
    tick();
    bus.FLUSH = 0; bus.ADDR_VALID = 0;
    m_flush();
    #1;
    n_checks++;
    if (bus.ADDR_TO_L2_VALID !== 1'b0) begin
      n_fail++; $display("FAIL flush-idle: l2valid=%b, expected 0", bus.ADDR_TO_L2_VALID);
    end
    probe(32'h4000, 0);
  endtask

  task automatic test_flush_wait();
    fetch(32'h2000, 0, 0, 0, 32'h2000, 0);
    fetch(32'h1000, 0, 1, 1, 32'h1000, 0);
    probe(32'h1000, 0);
    probe(32'h2000, 0);
    fetch(32'h1000, 1, 0, 0, 32'h1000, 0);
    fetch(32'h7000, 0, 0, 2, 32'h7000, 0);
  endtask

  task automatic test_addr_change();
    bus.FLUSH = 1; tick(); bus.FLUSH = 0; m_flush();
    fetch(32'h1000, 0, 1, 0, 32'h2000, 0);
    fetch(32'h2000, 0, 0, 0, 32'h2000, 0);
    probe(32'h1000, 1);
  endtask

  task automatic test_reset_wait();
    bus.ADDR = 32'h5000; bus.ADDR_VALID = 1; bus.ADDR_TO_L2_READY = 1;
    tick();
    tick();
    RST = 1;
    tick();
    RST = 0; bus.ADDR_VALID = 0; bus.ADDR_TO_L2_READY = 0;
    m_flush();
    #1;
    n_checks++;
    if (bus.ADDR_TO_L2_VALID !== 1'b0 || bus.CACHE_READY !== 1'b0 || bus.DATA !== 32'h0) begin
      n_fail++; $display("FAIL reset-wait: l2valid=%b ready=%b data=%h, expected 0 0 0", bus.ADDR_TO_L2_VALID, bus.CACHE_READY, bus.DATA);
    end
    probe(32'h1000, 0);
    probe(32'h2000, 0);
  endtask

  task automatic test_random();
    logic [31:0] tags [4] = '{32'h1, 32'h2, 32'h3, 32'h5};
    logic [31:0] sets [3] = '{32'h0, 32'h1, 32'h7};
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a, alt;
      int r = int'($urandom_range(0, 9));
      a = (tags[$urandom_range(0, 3)] << 12) | (sets[$urandom_range(0, 2)] << 5) | ($urandom_range(0, 7) << 2);
      alt = ($urandom_range(0, 5) == 0) ? ((tags[$urandom_range(0, 3)] << 12) | ($urandom_range(0, 7) << 2)) : a;
      fetch(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), r == 0 ? 1 : (r == 1 ? 2 : 0), alt, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_replacement();
    test_backpressure();
    test_flush_idle();
    test_flush_wait();
    test_addr_change();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache replacing the direct-mapped fetch cache between the IF stage and the L2. Lookup is combinational on the fetch address. A miss runs a request/wait/fill FSM with a ready/valid handshake to L2. Victim choice is invalid-way-first, then a per-set round-robin pointer. FLUSH invalidates the whole cache in one cycle and safely discards any fill already in flight.

## Interface
- DATA_WIDTH, 32: fetch word width; power of 2, ≥ 8.
- ADDR_WIDTH, 32: byte address width.
- BLOCK_WORDS, 8: words per line; power of 2.
- SETS, 128: number of sets; power of 2.
- WAYS, 2: associativity; power of 2, ≥ 1.
- Derived widths:
  - OFFSET = log2(BLOCK_WORDS·DATA_WIDTH/8)
  - WOFF = log2(DATA_WIDTH/8)
  - INDEX = log2(SETS)
  - TAG = ADDR_WIDTH − INDEX − OFFSET
  - LINE = BLOCK_WORDS·DATA_WIDTH
- Ports:
  - CLK  in  1  clock.
  - RST  in  1  reset; synchronous, active-high.
  - FLUSH  in  1  invalidate all lines.
  - ADDR  in  ADDR_WIDTH  fetch byte address.
  - ADDR_VALID  in  1  fetch request.
  - DATA  out  DATA_WIDTH  fetched word.
  - CACHE_READY  out  1  DATA valid for ADDR this cycle.
  - ADDR_TO_L2_VALID  out  1  line request valid.
  - ADDR_TO_L2_READY  in  1  L2 accepts the request.
  - ADDR_TO_L2  out  ADDR_WIDTH−OFFSET  line address, ADDR[ADDR_WIDTH−1:OFFSET].
  - DATA_FROM_L2  in  LINE  refill line; word 0 in the LSBs.
  - DATA_FROM_L2_VALID  in  1  one-cycle refill pulse.

## Operation
- Address split: tag = ADDR[ADDR_WIDTH−1:INDEX+OFFSET]; set = ADDR[INDEX+OFFSET−1:OFFSET]; word = ADDR[OFFSET−1:WOFF].
- Hit: state IDLE, ADDR_VALID=1, and exactly one way has valid=1 with a matching tag. On a hit, CACHE_READY=1 and DATA = the selected word of that way.
- DATA=0 whenever CACHE_READY=0. CACHE_READY is 0 in every state other than IDLE.
- FSM states:
  - IDLE: ADDR_VALID and no hit → latch ADDR into miss_addr, go to REQ.
  - REQ: ADDR_TO_L2_VALID=1 and ADDR_TO_L2 = miss_addr line address; both held stable until ADDR_TO_L2_READY=1, then go to WAIT.
  - WAIT: on DATA_FROM_L2_VALID, capture the line into the fill register, go to FILL. DATA_FROM_L2_VALID in any other state is ignored.
  - FILL: write the victim way of miss_addr's set (data, tag, valid=1), go to IDLE.
- Fill always targets miss_addr. ADDR changing during a miss does not redirect the fill; the new ADDR is looked up when the FSM returns to IDLE.
- Victim selection: lowest-index invalid way, pointer unchanged. If all ways are valid, use rr_ptr[set] and increment it modulo WAYS.
- FLUSH (any state): clear all valid bits and all rr_ptr next edge.
  - In REQ or WAIT: set a discard flag. The handshake still completes; the response is dropped (no write) and the FSM goes straight from WAIT to IDLE.
  - In FILL: the write is suppressed.
  - FLUSH in IDLE with a miss present: flush takes effect and the miss is not started that cycle.
- RST: state IDLE, all valid=0, rr_ptr=0, discard=0, ADDR_TO_L2_VALID=0, ADDR_TO_L2=0. Resulting CACHE_READY=0, DATA=0.
- RST mid-miss abandons the request. L2 is reset by the same RST.

## Timing
- Hit latency: 0 cycles, combinational from ADDR.
- Miss at cycle 0 → REQ at cycle 1.
- With READY=1 and L2 responding at the first WAIT cycle (cycle 2): FILL at cycle 3, hit visible at cycle 4.
- One outstanding request maximum. No lookups are serviced during a miss.
- The array write happens at the clock edge ending FILL; the same-cycle hit path does not see it.

## Structure
- Package icache_pkg: state enum {IDLE, REQ, WAIT, FILL} and the width helper functions (OFFSET, INDEX, TAG).
- Sub-module icache_way: one way's data, tag and valid arrays.
  - Asynchronous read, one synchronous write port, single-cycle valid clear.
  - Instantiated WAYS times via generate.
- The top level holds the FSM, the rr_ptr array, the hit/word mux and the victim logic.

## Test plan
Defaults assumed for all scenarios: line 32 B; set = ADDR[11:5]; tag = ADDR[31:12].
- Cold miss:
  - Stimulus: after reset, ADDR=0x1000 valid, READY=1, L2 returns words 0x100..0x107.
  - Response: ADDR_TO_L2=0x80 at cycle 1; CACHE_READY=1 with DATA=0x100 at cycle 4; then ADDR=0x1004 → DATA=0x101 in the same cycle.
- Replacement:
  - Stimulus: fill 0x1000 (way0) and 0x2000 (way1), both then hit; then miss on 0x3000.
  - Response: 0x3000 evicts way0 and rr_ptr[0] becomes 1; 0x1000 now misses, 0x2000 still hits.
- Backpressure:
  - Stimulus: READY=0 for 5 cycles during REQ.
  - Response: ADDR_TO_L2_VALID and ADDR_TO_L2 held constant; exactly one request accepted.
- Flush in WAIT:
  - Stimulus: FLUSH while WAIT is pending the 0x1000 response.
  - Response: the response is dropped; 0x1000 and the previously cached 0x2000 both miss and issue new requests.
- ADDR change in WAIT:
  - Stimulus: ADDR switches from 0x1000 to 0x2000 while in WAIT.
  - Response: the 0x1000 line is filled; a new request with ADDR_TO_L2=0x100 follows.
- Reset in WAIT:
  - Stimulus: RST while in WAIT.
  - Response: ADDR_TO_L2_VALID=0, CACHE_READY=0, DATA=0 next cycle; every prior line misses.
